// File: rtl/pipe_tx_pkg.sv
// -----------------------------------------------------------------------------
// pipe_tx_pkg
// Shared definitions for the host pipe-out transmit path: the arbiter state
// encoding, the block header magic byte and the default block geometry that
// the pipe_tx_fifo instances and pipe_tx_arbiter agree on.
// -----------------------------------------------------------------------------
package pipe_tx_pkg;

    // Arbiter state encoding (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Magic byte carried in the optional per-block header word
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Default block geometry shared with the per-channel FIFOs
    localparam int DEFAULT_BLOCK_LEN = 1024;
    localparam int DEFAULT_DW        = 16;

    // Header word layout: magic byte above a zero-extended channel index
    function automatic logic [15:0] hdr_word(input logic [7:0] ch);
        return {HDR_MAGIC, ch};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the request vector upward starting
// at last_grant+1 (wrapping modulo N_CH) and returns the first requester.
//
// Ports:
//   req        in   N_CH  request vector
//   last_grant in   CHW   index granted most recently (lowest priority now)
//   grant      out  CHW   selected index (0 when nothing requests)
//   valid      out  1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CHW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CHW-1:0]  last_grant,
    output logic [CHW-1:0]  grant,
    output logic            valid
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // last_grant is the final (winning) assignment. Offset N_CH lands on
    // last_grant itself, which therefore only wins when it is alone.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % N_CH;
            if (req[idx]) begin
                grant = CHW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_tx_arbiter
// Shares the single host pipe-out endpoint between N_CH pipe transmit FIFOs.
// A channel raising ch_ready (FIFO half full) is granted in round-robin order
// and owns the port for exactly one block. Everything runs on rd_clk.
//
// Ports:
//   rd_clk      in   1        host/pipe clock, posedge
//   rst         in   1        synchronous active-high reset
//   ch_ready    in   N_CH     per-channel block-available flag
//   ch_dout     in   N_CH*DW  per-channel FIFO data, channel k at [k*DW +: DW]
//   ch_rd_en    out  N_CH     per-channel FIFO read strobe (one-hot or zero)
//   pipe_read   in   1        host read strobe, one word per high cycle
//   pipe_dout   out  DW       word presented to the host endpoint
//   pipe_ready  out  1        a granted block is waiting for the host
//   busy        out  1        block transfer in progress
//   active_ch   out  CHW      currently granted channel
//
// Build option:
//   PIPE_TX_ARB_HEADER_EN  prefix each block with one header word
//                          {HDR_MAGIC, zero-extended active_ch}; the header
//                          strobe pops no FIFO, so the host block is
//                          BLOCK_LEN+1 words long.
// -----------------------------------------------------------------------------
module pipe_tx_arbiter
    import pipe_tx_pkg::*;
#(
    parameter int  N_CH      = 4,
    parameter int  BLOCK_LEN = DEFAULT_BLOCK_LEN,
    parameter int  DW        = DEFAULT_DW,
    localparam int CHW       = $clog2(N_CH)
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_ready,
    input  logic [N_CH*DW-1:0] ch_dout,
    output logic [N_CH-1:0]  ch_rd_en,
    input  logic             pipe_read,
    output logic [DW-1:0]    pipe_dout,
    output logic             pipe_ready,
    output logic             busy,
    output logic [CHW-1:0]   active_ch
);

    localparam int CNTW = $clog2(BLOCK_LEN + 1);
`ifdef PIPE_TX_ARB_HEADER_EN
    localparam int LAST_CNT = BLOCK_LEN;
`else
    localparam int LAST_CNT = BLOCK_LEN - 1;
`endif

    logic [1:0]      state;
    logic [CHW-1:0]  last_grant;
    logic [CNTW-1:0] count;
    logic [CHW-1:0]  pick;
    logic            pick_valid;
    logic            granted;
`ifdef PIPE_TX_ARB_HEADER_EN
    logic            hdr_pend;
`endif

    rr_arbiter #(
        .N_CH (N_CH),
        .CHW  (CHW)
    ) u_rr (
        .req        (ch_ready),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign granted = (state == ST_ARMED) || (state == ST_READ);

    // ---- control: grant / block sequencing ----
    // ARMED and READ share the strobe handling: the first strobe in ARMED is
    // word 0 (or the header) and moves to READ; the strobe that hits the
    // terminal count returns to IDLE from either state. The count never wraps.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pipe_ready <= 1'b0;
            busy       <= 1'b0;
            active_ch  <= '0;
            last_grant <= CHW'(N_CH - 1);
            count      <= '0;
`ifdef PIPE_TX_ARB_HEADER_EN
            hdr_pend   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        active_ch  <= pick;
                        state      <= ST_ARMED;
                        pipe_ready <= 1'b1;
`ifdef PIPE_TX_ARB_HEADER_EN
                        hdr_pend   <= 1'b1;
`endif
                    end
                end
                ST_ARMED, ST_READ: begin
                    if (pipe_read) begin
                        pipe_ready <= 1'b0;
`ifdef PIPE_TX_ARB_HEADER_EN
                        hdr_pend   <= 1'b0;
`endif
                        if (count == CNTW'(LAST_CNT)) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            last_grant <= active_ch;
                            count      <= '0;
                        end else begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    pipe_ready <= 1'b0;
                    busy       <= 1'b0;
                    count      <= '0;
                end
            endcase
        end
    end

    // ---- read path: combinational mux, no added latency ----
    // The host strobe is forwarded straight to the granted FIFO so its
    // first-word-fall-through data appears on pipe_dout in the same cycle.
    always_comb begin
        ch_rd_en  = '0;
        pipe_dout = '0;
        if (granted) begin
            pipe_dout = ch_dout[int'(active_ch)*DW +: DW];
`ifdef PIPE_TX_ARB_HEADER_EN
            if (hdr_pend) begin
                pipe_dout = DW'(hdr_word(8'(active_ch)));
            end else if (pipe_read) begin
                ch_rd_en[active_ch] = 1'b1;
            end
`else
            if (pipe_read) begin
                ch_rd_en[active_ch] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipe_tx_arbiter.sv
module tb_pipe_tx_arbiter;

    localparam int N_CH      = 4;
    localparam int BLOCK_LEN = 1024;
    localparam int DW        = 16;
    localparam int CHW       = 2;
`ifdef PIPE_TX_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                 rd_clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_CH-1:0]      ch_ready = '0;
    logic [N_CH*DW-1:0]   ch_dout;
    logic [N_CH-1:0]      ch_rd_en;
    logic                 pipe_read = 1'b0;
    logic [DW-1:0]        pipe_dout;
    logic                 pipe_ready;
    logic                 busy;
    logic [CHW-1:0]       active_ch;

    int errors = 0;
    int checks = 0;

    // FIFO model pointers (advanced by DUT pops) and the bench's own
    // expectation of where each FIFO should be.
    logic [11:0] fifo_ptr [N_CH] = '{default: '0};
    logic [11:0] exp_ptr  [N_CH] = '{default: '0};
    logic [DW-1:0] sb [$];

    always #5 rd_clk = ~rd_clk;

    pipe_tx_arbiter #(
        .N_CH      (N_CH),
        .BLOCK_LEN (BLOCK_LEN),
        .DW        (DW)
    ) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .ch_ready   (ch_ready),
        .ch_dout    (ch_dout),
        .ch_rd_en   (ch_rd_en),
        .pipe_read  (pipe_read),
        .pipe_dout  (pipe_dout),
        .pipe_ready (pipe_ready),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_dout
        assign ch_dout[k*DW +: DW] = {4'(k), fifo_ptr[k]};
    end

    always @(posedge rd_clk) begin
        for (int k = 0; k < N_CH; k++)
            if (ch_rd_en[k]) fifo_ptr[k] <= fifo_ptr[k] + 12'd1;
    end

    task automatic do_reset();
        @(negedge rd_clk);
        rst = 1'b1; pipe_read = 1'b0; ch_ready = '0;
        repeat (2) @(negedge rd_clk);
        rst = 1'b0;
    endtask

    // Drives one host strobe in the current cycle (caller is at a negedge).
    task automatic strobe(input int ch, input bit is_hdr, input string tag);
        logic [DW-1:0]   exp_d;
        logic [N_CH-1:0] exp_en;
        pipe_read = 1'b1;
        if (is_hdr) begin
            sb.push_back({8'hA5, 8'(ch)});
            exp_en = '0;
        end else begin
            sb.push_back({4'(ch), exp_ptr[ch]});
            exp_ptr[ch] = exp_ptr[ch] + 12'd1;
            exp_en = N_CH'(1) << ch;
        end
        #1;
        exp_d = sb.pop_front();
        checks++;
        if (ch_rd_en !== exp_en) begin
            errors++;
            $display("FAIL %s rd_en: got %b want %b", tag, ch_rd_en, exp_en);
        end
        checks++;
        if (pipe_dout !== exp_d) begin
            errors++;
            $display("FAIL %s dout: got %h want %h", tag, pipe_dout, exp_d);
        end
    endtask

    task automatic wait_grant(input int ch, input string tag, output int waited);
        waited = 0;
        while (waited < 16) begin
            @(negedge rd_clk);
            pipe_read = 1'b0;
            #1;
            waited++;
            if (pipe_ready === 1'b1) break;
        end
        checks++;
        if (pipe_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s grant_timeout: pipe_ready=%b after %0d cycles want 1", tag, pipe_ready, waited);
        end
        checks++;
        if (active_ch !== CHW'(ch) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: active_ch=%0d busy=%b want ch=%0d busy=0", tag, active_ch, busy, ch);
        end
    endtask

    task automatic run_block(input int ch, input int gaps, input int drop_at,
                             input logic [N_CH-1:0] next_ready, input string tag);
        int total;
        int w;
        total = BLOCK_LEN + HDR;
        wait_grant(ch, tag, w);
        for (int i = 0; i < total; i++) begin
            @(negedge rd_clk);
            if (i == drop_at) ch_ready[ch] = 1'b0;
            if (i == total - 1) ch_ready = next_ready;
            strobe(ch, (HDR != 0) && (i == 0), tag);
            checks++;
            if (busy !== (i > 0) || pipe_ready !== (i == 0)) begin
                errors++;
                $display("FAIL %s word%0d flags: busy=%b pipe_ready=%b want %b %b", tag, i, busy, pipe_ready, (i > 0), (i == 0));
            end
            if (i < total - 1) begin
                for (int g = 0; g < gaps; g++) begin
                    @(negedge rd_clk);
                    pipe_read = 1'b0;
                    #1;
                    checks++;
                    if (busy !== 1'b1 || ch_rd_en !== '0) begin
                        errors++;
                        $display("FAIL %s gap%0d: busy=%b rd_en=%b want 1 0000", tag, i, busy, ch_rd_en);
                    end
                end
            end
        end
        @(negedge rd_clk);
        pipe_read = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pipe_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s end: busy=%b pipe_ready=%b want 0 0", tag, busy, pipe_ready);
        end
        checks++;
        if (fifo_ptr[ch] !== exp_ptr[ch]) begin
            errors++;
            $display("FAIL %s pops: fifo_ptr=%0d want %0d", tag, fifo_ptr[ch], exp_ptr[ch]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (pipe_ready !== 1'b0 || busy !== 1'b0 || active_ch !== '0 || ch_rd_en !== '0) begin
            errors++;
            $display("FAIL reset: pipe_ready=%b busy=%b active_ch=%0d rd_en=%b want 0 0 0 0000", pipe_ready, busy, active_ch, ch_rd_en);
        end
        @(negedge rd_clk);
        pipe_read = 1'b1;
        #1;
        checks++;
        if (ch_rd_en !== '0 || pipe_dout !== '0) begin
            errors++;
            $display("FAIL idle_read: rd_en=%b dout=%h want 0000 0000", ch_rd_en, pipe_dout);
        end
    endtask

    task automatic test_single();
        int w;
        @(negedge rd_clk);
        pipe_read = 1'b0;
        ch_ready = 4'b0100;
        wait_grant(2, "single_arm", w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL single_latency: pipe_ready after %0d cycles want 1", w);
        end
        // Block already armed: run_block's wait sees pipe_ready immediately.
        run_block(2, 0, -1, 4'b0000, "single");
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        ch_ready = 4'b1111;
        for (int b = 0; b < 5; b++)
            run_block(order[b], 0, -1, (b == 4) ? 4'b0000 : 4'b1111, "rr");
    endtask

    task automatic test_duty();
        @(negedge rd_clk);
        ch_ready = 4'b0010;
        run_block(1, 2, -1, 4'b0000, "duty");
    endtask

    task automatic test_drop();
        @(negedge rd_clk);
        ch_ready = 4'b1000;
        // Channel 1 requests on the final strobe; it must win the next IDLE.
        run_block(3, 0, 10, 4'b0010, "drop");
    endtask

    task automatic test_reset_mid();
        int w;
        wait_grant(1, "rstmid", w);
        for (int i = 0; i < 500; i++) begin
            @(negedge rd_clk);
            strobe(1, (HDR != 0) && (i == 0), "rstmid");
        end
        @(negedge rd_clk);
        pipe_read = 1'b0;
        rst = 1'b1;
        ch_ready = 4'b0011;
        @(negedge rd_clk);
        rst = 1'b0;
        pipe_read = 1'b1;
        #1;
        checks++;
        if (ch_rd_en !== '0 || busy !== 1'b0 || pipe_ready !== 1'b0 || pipe_dout !== '0) begin
            errors++;
            $display("FAIL rstmid_abort: rd_en=%b busy=%b pipe_ready=%b dout=%h want 0000 0 0 0000", ch_rd_en, busy, pipe_ready, pipe_dout);
        end
        checks++;
        if (fifo_ptr[1] !== exp_ptr[1]) begin
            errors++;
            $display("FAIL rstmid_pops: fifo_ptr=%0d want %0d", fifo_ptr[1], exp_ptr[1]);
        end
        run_block(0, 0, -1, 4'b0000, "after_rst");
    endtask

`ifdef PIPE_TX_ARB_HEADER_EN
    task automatic test_header();
        do_reset();
        ch_ready = 4'b1000;
        run_block(3, 0, -1, 4'b0000, "header");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_duty();
        test_drop();
        test_reset_mid();
`ifdef PIPE_TX_ARB_HEADER_EN
        test_header();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
